bpsk_demod_deser: RTL and testbench

BPSK_DEMOD_DESER -- requirements
Module: bpsk_demod_deser

---
 rtl/bpsk_pkg.sv | 21 ++
 rtl/bpsk_slicer.sv | 34 +++
 rtl/bpsk_demod_deser.sv | 161 ++++++++++++++++
 tb/tb_bpsk_demod_deser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: symbol encodings, default frame/sample sizes and
// the deserializer state type. Used by both the demodulator and modulator side.
`timescale 1ns/1ps
package bpsk_pkg;

   // Antipodal symbol encodings (+1 / -1) for the modulator side
   localparam logic [1:0] SYM_POS = 2'b01;
   localparam logic [1:0] SYM_NEG = 2'b11;

   // Default codeword lengths and channel sample width
   localparam int N_HAMMING = 12;
   localparam int N_BCH     = 15;
   localparam int SAMPLE_W  = 4;

   // Deserializer framing states
   typedef enum logic {
      COLLECT = 1'b0,
      STALL   = 1'b1
   } deser_state_e;

endpackage

// File: rtl/bpsk_slicer.sv
// Hard-decision BPSK slicer: sign of the sample gives the bit, and a magnitude
// below THRESH marks the sample as weak (low confidence).
`timescale 1ns/1ps
module bpsk_slicer
   import bpsk_pkg::*;
#(
   parameter int W      = SAMPLE_W,
   parameter int THRESH = 1
) (
   input  logic signed [W-1:0] sample_i,
   output logic                bit_o,
   output logic                weak_o
);

   // |s| is formed one bit wider so the most negative code maps to 2^(W-1)
   function automatic logic [W:0] mag_of(input logic signed [W-1:0] s);
      logic signed [W:0] ext;
      ext = {s[W-1], s};
      if (ext[W]) begin
         return $unsigned(-ext);
      end
      return $unsigned(ext);
   endfunction

   logic [W:0] mag;

   // Decision is purely combinational: negative -> bit 1, zero/positive -> bit 0
   always_comb begin
      mag    = mag_of(sample_i);
      bit_o  = sample_i[W-1];
      weak_o = (int'(mag) < THRESH);
   end

endmodule

// File: rtl/bpsk_demod_deser.sv
// BPSK demodulator deserializer: slices each accepted sample, packs N decisions
// LSB-first into a codeword with a weak-sample count, and hands the word to a
// decoder over a valid/ready port. One extra word can be held while the output
// register is blocked; beyond that the input is stalled.
`timescale 1ns/1ps
module bpsk_demod_deser
   import bpsk_pkg::*;
#(
   parameter int N      = N_HAMMING,
   parameter int W      = SAMPLE_W,
   parameter int THRESH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [W-1:0]      s_data,
   input  logic                     s_sof,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic [N-1:0]             o_data,
   output logic [$clog2(N+1)-1:0]   o_weak,
   output logic                     o_sync_err
);

   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam int            KW   = $clog2(N+1);
   localparam logic [CW-1:0] LAST = CW'(N-1);

   deser_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  part_data_q, part_data_d;
   logic [KW-1:0] part_weak_q, part_weak_d;
   logic [N-1:0]  held_data_q, held_data_d;
   logic [KW-1:0] held_weak_q, held_weak_d;
   logic [N-1:0]  out_data_q, out_data_d;
   logic [KW-1:0] out_weak_q, out_weak_d;
   logic          out_valid_q, out_valid_d;
   logic          sync_err_q, sync_err_d;

   logic          dec_bit;
   logic          dec_weak;
   logic          accept;
   logic          drain;
   logic          restart;
   logic [CW-1:0] pos;
   logic [N-1:0]  word;
   logic [KW-1:0] word_weak;

   bpsk_slicer #(
      .W      (W),
      .THRESH (THRESH)
   ) u_slicer (
      .sample_i (s_data),
      .bit_o    (dec_bit),
      .weak_o   (dec_weak)
   );

   assign s_ready    = (state_q == COLLECT);
   assign o_valid    = out_valid_q;
   assign o_data     = out_data_q;
   assign o_weak     = out_weak_q;
   assign o_sync_err = sync_err_q;

   // Next-state: bit packing, frame completion, output hand-off and resync
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      part_data_d = part_data_q;
      part_weak_d = part_weak_q;
      held_data_d = held_data_q;
      held_weak_d = held_weak_q;
      out_data_d  = out_data_q;
      out_weak_d  = out_weak_q;
      out_valid_d = out_valid_q;
      sync_err_d  = 1'b0;

      accept    = s_valid && (state_q == COLLECT);
      drain     = out_valid_q && o_ready;
      restart   = s_sof && (cnt_q != '0);
      pos       = restart ? '0 : cnt_q;
      word      = restart ? '0 : part_data_q;
      word_weak = restart ? '0 : part_weak_q;

      // A drained word leaves the register unless something reloads it below
      if (drain) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         COLLECT: begin
            if (accept) begin
               word[pos] = dec_bit;
               word_weak = word_weak + KW'(dec_weak);
               if (restart) begin
                  sync_err_d = 1'b1;
               end
               if (pos == LAST) begin
                  part_data_d = '0;
                  part_weak_d = '0;
                  cnt_d       = '0;
                  if (!out_valid_q || drain) begin
                     out_data_d  = word;
                     out_weak_d  = word_weak;
                     out_valid_d = 1'b1;
                  end else begin
                     held_data_d = word;
                     held_weak_d = word_weak;
                     state_d     = STALL;
                  end
               end else begin
                  part_data_d = word;
                  part_weak_d = word_weak;
                  cnt_d       = pos + CW'(1);
               end
            end
         end
         STALL: begin
            if (drain) begin
               out_data_d  = held_data_q;
               out_weak_d  = held_weak_q;
               out_valid_d = 1'b1;
               held_data_d = '0;
               held_weak_d = '0;
               state_d     = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // State and datapath registers; reset abandons any partial or held frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         cnt_q       <= '0;
         part_data_q <= '0;
         part_weak_q <= '0;
         held_data_q <= '0;
         held_weak_q <= '0;
         out_data_q  <= '0;
         out_weak_q  <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         part_data_q <= part_data_d;
         part_weak_q <= part_weak_d;
         held_data_q <= held_data_d;
         held_weak_q <= held_weak_d;
         out_data_q  <= out_data_d;
         out_weak_q  <= out_weak_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end
   end

endmodule

// File: tb/tb_bpsk_demod_deser.sv
// Testbench for bpsk_demod_deser: directed framing scenarios on an N=12
// instance and a randomly throttled 1000-frame run on an N=15 instance, both
// compared against a sample-list reference model.
`timescale 1ns/1ps
module tb_bpsk_demod_deser;

   localparam int NA = 12;
   localparam int NB = 15;
   localparam int W  = 4;
   localparam int TA = 1;
   localparam int TB = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                      a_s_valid, a_s_ready, a_s_sof;
   logic signed [W-1:0]       a_s_data;
   logic                      a_o_valid, a_o_ready, a_o_sync_err;
   logic [NA-1:0]             a_o_data;
   logic [$clog2(NA+1)-1:0]   a_o_weak;

   logic                      b_s_valid, b_s_ready, b_s_sof;
   logic signed [W-1:0]       b_s_data;
   logic                      b_o_valid, b_o_ready, b_o_sync_err;
   logic [NB-1:0]             b_o_data;
   logic [$clog2(NB+1)-1:0]   b_o_weak;

   bpsk_demod_deser #(.N(NA), .W(W), .THRESH(TA)) dut_a (
      .clk(clk), .rst(rst),
      .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_sof(a_s_sof),
      .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data), .o_weak(a_o_weak),
      .o_sync_err(a_o_sync_err)
   );

   bpsk_demod_deser #(.N(NB), .W(W), .THRESH(TB)) dut_b (
      .clk(clk), .rst(rst),
      .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_sof(b_s_sof),
      .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_weak(b_o_weak),
      .o_sync_err(b_o_sync_err)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference model: a frame is just the list of accepted sample values
   function automatic int mdl_data(input int q[$]);
      int d = 0;
      foreach (q[k]) begin
         if (q[k] < 0) d = d | (1 << k);
      end
      return d;
   endfunction

   function automatic int mdl_weak(input int q[$], input int th);
      int c = 0;
      foreach (q[k]) begin
         int m;
         m = (q[k] < 0) ? -q[k] : q[k];
         if (m < th) c++;
      end
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int a_frm[$];
   int a_exp_data;
   int a_exp_weak;

   // Offer one sample to instance A, wait for it to be taken, update the model
   task automatic send_a(input int v, input logic sof);
      int t;
      a_s_valid = 1'b1;
      a_s_data  = W'(v);
      a_s_sof   = sof;
      t = 0;
      while (!a_s_ready && t < 200) begin
         step();
         t++;
      end
      chk("a_ready_wait", 32'(a_s_ready), 1);
      step();
      a_s_valid = 1'b0;
      a_s_sof   = 1'b0;
      if (sof && a_frm.size() != 0) a_frm.delete();
      a_frm.push_back(v);
      if (a_frm.size() == NA) begin
         a_exp_data = mdl_data(a_frm);
         a_exp_weak = mdl_weak(a_frm, TA);
         a_frm.delete();
      end
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, 15)) - 8;
   endfunction

   int s1[12] = '{7, -8, 1, -1, 0, 3, -3, 7, -7, 1, -2, 2};
   int w1, k1, w2, k2;

   int bq_data[$];
   int bq_weak[$];
   int bfrm[$];
   int b_gen, b_rcv, sync_exp, sync_obs, cyc;

   initial begin
      rst = 1'b1;
      a_s_valid = 1'b0; a_s_data = '0; a_s_sof = 1'b0; a_o_ready = 1'b1;
      b_s_valid = 1'b0; b_s_data = '0; b_s_sof = 1'b0; b_o_ready = 1'b0;
      repeat (3) step();
      chk("rst_valid", 32'(a_o_valid), 0);
      chk("rst_data", 32'(a_o_data), 0);
      chk("rst_weak", 32'(a_o_weak), 0);
      chk("rst_sync", 32'(a_o_sync_err), 0);
      chk("rst_ready", 32'(a_s_ready), 1);
      chk("rst_ready_b", 32'(b_s_ready), 1);
      rst = 1'b0;

      // Reference frame, consumer always ready
      for (int i = 0; i < 11; i++) send_a(s1[i], i == 0);
      chk("s1_early_valid", 32'(a_o_valid), 0);
      send_a(s1[11], 1'b0);
      chk("s1_valid", 32'(a_o_valid), 1);
      chk("s1_data", 32'(a_o_data), a_exp_data);
      chk("s1_weak", 32'(a_o_weak), a_exp_weak);
      step();
      chk("s1_drained", 32'(a_o_valid), 0);

      // Back-pressure: second full word stalls the input
      a_o_ready = 1'b0;
      for (int i = 0; i < 12; i++) send_a(rnd_sample(), 1'b0);
      w1 = a_exp_data; k1 = a_exp_weak;
      chk("st_w1_valid", 32'(a_o_valid), 1);
      for (int i = 0; i < 12; i++) send_a(rnd_sample(), 1'b0);
      w2 = a_exp_data; k2 = a_exp_weak;
      chk("st_ready_low", 32'(a_s_ready), 0);
      chk("st_hold_data", 32'(a_o_data), w1);
      chk("st_hold_weak", 32'(a_o_weak), k1);
      step();
      chk("st_still_low", 32'(a_s_ready), 0);
      chk("st_stable", 32'(a_o_data), w1);
      a_o_ready = 1'b1;
      step();
      chk("st_w2_valid", 32'(a_o_valid), 1);
      chk("st_w2_data", 32'(a_o_data), w2);
      chk("st_w2_weak", 32'(a_o_weak), k2);
      chk("st_ready_back", 32'(a_s_ready), 1);
      step();
      chk("st_w2_drained", 32'(a_o_valid), 0);

      // Mid-frame start-of-frame resynchronises
      for (int i = 0; i < 5; i++) send_a(rnd_sample(), i == 0);
      chk("sy_pre", 32'(a_o_sync_err), 0);
      send_a(rnd_sample(), 1'b1);
      chk("sy_pulse", 32'(a_o_sync_err), 1);
      send_a(rnd_sample(), 1'b0);
      chk("sy_clear", 32'(a_o_sync_err), 0);
      for (int i = 0; i < 10; i++) send_a(rnd_sample(), 1'b0);
      chk("sy_valid", 32'(a_o_valid), 1);
      chk("sy_data", 32'(a_o_data), a_exp_data);
      chk("sy_weak", 32'(a_o_weak), a_exp_weak);
      step();

      // All-zero samples: every bit 0 and every sample weak
      for (int i = 0; i < 12; i++) send_a(0, 1'b0);
      chk("z_data", 32'(a_o_data), a_exp_data);
      chk("z_weak", 32'(a_o_weak), a_exp_weak);
      step();

      // Reset mid-frame, then reset while stalled
      for (int i = 0; i < 6; i++) send_a(rnd_sample(), 1'b0);
      rst = 1'b1; step(); rst = 1'b0;
      a_frm.delete();
      chk("r1_valid", 32'(a_o_valid), 0);
      chk("r1_ready", 32'(a_s_ready), 1);
      chk("r1_sync", 32'(a_o_sync_err), 0);
      a_o_ready = 1'b0;
      for (int i = 0; i < 24; i++) send_a(rnd_sample(), 1'b0);
      chk("r2_stalled", 32'(a_s_ready), 0);
      rst = 1'b1; step(); rst = 1'b0;
      a_frm.delete();
      chk("r2_valid", 32'(a_o_valid), 0);
      chk("r2_data", 32'(a_o_data), 0);
      chk("r2_weak", 32'(a_o_weak), 0);
      chk("r2_ready", 32'(a_s_ready), 1);
      chk("r2_sync", 32'(a_o_sync_err), 0);
      a_o_ready = 1'b1;
      for (int i = 0; i < 12; i++) send_a(rnd_sample(), 1'b0);
      chk("r3_valid", 32'(a_o_valid), 1);
      chk("r3_data", 32'(a_o_data), a_exp_data);
      chk("r3_weak", 32'(a_o_weak), a_exp_weak);
      step();

      // Random throttled traffic on the N=15 instance
      b_gen = 0; b_rcv = 0; sync_exp = 0; sync_obs = 0; cyc = 0;
      while (cyc < 80000 && !(b_gen >= 1000 && bq_data.size() == 0 && !b_o_valid)) begin
         b_o_ready = ($urandom_range(0, 9) < 7);
         if (b_gen < 1000) begin
            b_s_valid = ($urandom_range(0, 3) != 0);
            b_s_data  = W'($urandom_range(0, 15));
            if (bfrm.size() == 0) b_s_sof = 1'($urandom_range(0, 1));
            else                  b_s_sof = ($urandom_range(0, 199) == 0);
         end else begin
            b_s_valid = 1'b0;
            b_s_sof   = 1'b0;
         end
         if (b_o_valid && b_o_ready) begin
            if (bq_data.size() == 0) begin
               chk("rnd_extra_word", 32'(bq_data.size()), 1);
            end else begin
               chk("rnd_data", 32'(b_o_data), bq_data.pop_front());
               chk("rnd_weak", 32'(b_o_weak), bq_weak.pop_front());
               b_rcv++;
            end
         end
         if (b_s_valid && b_s_ready) begin
            if (b_s_sof && bfrm.size() != 0) begin
               bfrm.delete();
               sync_exp++;
            end
            bfrm.push_back(int'(b_s_data));
            if (bfrm.size() == NB) begin
               bq_data.push_back(mdl_data(bfrm));
               bq_weak.push_back(mdl_weak(bfrm, TB));
               bfrm.delete();
               b_gen++;
            end
         end
         step();
         cyc++;
         if (b_o_sync_err) sync_obs++;
      end
      chk("rnd_in_time", 32'(cyc < 80000), 1);
      chk("rnd_frames", b_rcv, 1000);
      chk("rnd_left", bq_data.size(), 0);
      chk("rnd_sync_pulses", sync_obs, sync_exp);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
